// File: rtl/mem_arbiter.sv
// Arbitrates IF and LS onto one memory port, one outstanding transaction at a time.
// Latency: request in IDLE -> mem_req next cycle; at least 3 cycles per transaction.
// Backpressure: requests are held until their gnt; mem_gnt_i/mem_rvalid_i stall the FSM indefinitely.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_o
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;
  req_t       req_q, req_d;

  logic ls_win;
  logic gnt, rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      starve_q <= '0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      req_q    <= req_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    req_d    = req_q;
    ls_win   = 1'b0;
    gnt      = 1'b0;
    rvalid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ls_req_i || if_req_i) begin
          // LS has priority unless IF has already been passed over STARVE_MAX times
          ls_win  = ls_req_i && !(if_req_i && (starve_q == 4'(STARVE_MAX)));
          owner_d = ls_win ? OWN_LS : OWN_IF;
          if (ls_win) begin
            req_d.addr  = ls_addr_i;
            req_d.we    = ls_we_i;
            req_d.be    = ls_be_i;
            req_d.wdata = ls_wdata_i;
          end else begin
            req_d.addr  = if_addr_i;
            req_d.we    = 1'b0;
            req_d.be    = '1;
            req_d.wdata = '0;
          end
          if (ls_win && if_req_i)
            starve_d = (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
          else
            starve_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          gnt     = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (mem_rvalid_i) begin
          rvalid  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = req_q.we;
  assign mem_be_o    = req_q.be;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;

  assign if_gnt_o    = gnt && (owner_q == OWN_IF);
  assign ls_gnt_o    = gnt && (owner_q == OWN_LS);
  assign if_rvalid_o = rvalid && (owner_q == OWN_IF);
  assign ls_rvalid_o = rvalid && (owner_q == OWN_LS);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign ls_rdata_o  = ls_rvalid_o ? mem_rdata_i : '0;

  // ls_req_i is a raw input, so the stall is gated to stay low while in reset
  assign stall_o = rst && (ls_req_i ||
                   ((state_q != IDLE) && (owner_q == OWN_LS) && !ls_rvalid_o));

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external memory port between instruction fetch (IF) and load/store (LS) in the RISC-V core.
- Sequences one outstanding memory transaction at a time using req/gnt/rvalid handshakes.
- Gives LS priority, with a starvation guard for IF.
- Drives stall_o so the pipeline holds while an LS access is pending.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_MAX, 4, max consecutive LS grants while IF waits before IF is forced to win (1..15)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- if_req_i  in  1  IF read request, held until if_gnt_o
- if_addr_i  in  ADDR_W  IF fetch address
- if_gnt_o  out  1  IF request accepted by memory (1-cycle pulse)
- if_rvalid_o  out  1  IF read data valid (1-cycle pulse)
- if_rdata_o  out  DATA_W  IF read data
- ls_req_i  in  1  LS request, held until ls_gnt_o
- ls_we_i  in  1  LS write enable
- ls_be_i  in  DATA_W/8  LS byte enables
- ls_addr_i  in  ADDR_W  LS address
- ls_wdata_i  in  DATA_W  LS write data
- ls_gnt_o  out  1  LS request accepted (1-cycle pulse)
- ls_rvalid_o  out  1  LS response valid; read data, or write ack
- ls_rdata_o  out  DATA_W  LS read data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_W  memory read data
- stall_o  out  1  pipeline stall request

Behaviour:
- Reset:
  - clk single clock; rst asynchronous, active-low.
  - While rst=0, all outputs are 0, state=IDLE, owner=IF, starve_cnt=0, and the latched request registers are 0.
- FSM states: IDLE, REQ, RSP.
- IDLE: if any request is high, arbitrate at the clock edge, latch the winner's addr/we/be/wdata and owner, then go to REQ. Otherwise stay.
- Arbitration:
  - Only ls_req_i → LS wins. Only if_req_i → IF wins.
  - Both high → LS wins unless starve_cnt==STARVE_MAX, in which case IF wins.
- starve_cnt:
  - LS wins while if_req_i=1 → increment, saturating at STARVE_MAX.
  - IF wins, or arbitration happens with if_req_i=0 → cleared to 0.
- IF transactions always use mem_we_o=0 and mem_be_o all-ones.
- REQ state:
  - mem_req_o=1; mem_* are driven from the latched registers and are stable until gnt.
  - On mem_gnt_i=1, the owner's gnt_o is 1 in the same cycle (combinational), then go to RSP.
  - Without mem_gnt_i, stay in REQ; no timeout.
- RSP state:
  - mem_req_o=0.
  - On mem_rvalid_i=1, the owner's rvalid_o=1 and rdata_o=mem_rdata_i in the same cycle, then go to IDLE.
  - Writes also complete through mem_rvalid_i (acknowledge).
- Non-owner rvalid_o/gnt_o are always 0. rdata_o is 0 whenever the matching rvalid_o is 0.
- mem_rvalid_i in IDLE or REQ is ignored (no response routed, no state change).
- Latency:
  - Request high in IDLE at cycle 0 → mem_req_o at cycle 1.
  - gnt at cycle 1 at the earliest → rvalid at cycle 2 at the earliest.
  - Next arbitration in IDLE at cycle 3. Minimum 3 cycles per transaction.
- A requester dropping req while in REQ (protocol violation) does not cancel the transaction; it completes and rvalid is pulsed anyway.
- stall_o = ls_req_i | (state!=IDLE & owner==LS & ~ls_rvalid_o). Combinational.
- Reset asserted mid-transaction:
  - Immediate return to IDLE; the outstanding transaction is abandoned and no rvalid is issued.
  - A late mem_rvalid_i after reset is ignored per the IDLE rule.

Test Plan:
- IF only, if_addr_i=0x0000_0010, mem_gnt_i immediate, mem_rvalid_i next cycle with 0x0000_0013:
  - Required: mem_addr_o=0x10 and mem_we_o=0 at cycle 1; if_gnt_o at cycle 1; if_rvalid_o=1 with if_rdata_o=0x13 at cycle 2; stall_o stays 0.
- LS write, ls_addr_i=0x100, ls_wdata_i=0xDEADBEEF, ls_be_i=4'b0011, gnt delayed 3 cycles:
  - Required: mem_* held stable for all 4 REQ cycles; ls_gnt_o pulses once; stall_o=1 until ls_rvalid_o.
- IF and LS both requesting continuously, STARVE_MAX=4:
  - Required grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF…; starve_cnt returns to 0 after each IF grant.
- Spurious mem_rvalid_i=1 in IDLE and in REQ:
  - Required: no if_rvalid_o/ls_rvalid_o, no state change; the transaction completes correctly on the later real rvalid.
- rst=0 asserted while in RSP for an LS read:
  - Required: all outputs 0 immediately.
  - After release, a late mem_rvalid_i yields no ls_rvalid_o, and a new IF request proceeds normally with 3-cycle latency.
